hazard_tracker: RTL and testbench
=================================

Name: hazard_tracker

Overview:
- Producer side of the forwarding interface. Tracks the destination register and write-back enable of every in-flight instruction in the EXE, MEM and WB stages.
- Exports the MEM and WB destination information that the forwarding unit consumes.
- Decides when the ID-stage instruction must stall, and inserts bubbles into EXE when it does.
- Sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers. Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_ADDR_W, 4, register address width (equals `REG_ADDRESS_LEN).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_forwarding  in  1  1 selects forwarding-mode hazard rules.
- flush  in  1  branch taken: kill the ID instruction.
- ID_valid  in  1  ID holds a real instruction.
- ID_wb_en  in  1  ID instruction writes a register.
- ID_mem_r_en  in  1  ID instruction is a load.
- ID_dst  in  REG_ADDR_W  ID destination register.
- ID_src1  in  REG_ADDR_W  first source register.
- ID_src2  in  REG_ADDR_W  second source register.
- ID_two_src  in  1  ID_src2 is actually read.
- EXE_wb_en  out  1  tracked EXE write enable.
- EXE_dst  out  REG_ADDR_W  tracked EXE destination.
- EXE_mem_r_en  out  1  EXE instruction is a load.
- MEM_wb_en  out  1  to forwarding unit.
- MEM_dst  out  REG_ADDR_W  to forwarding unit.
- WB_wb_en  out  1  to forwarding unit.
- WB_dst  out  REG_ADDR_W  to forwarding unit.
- hazard_detected  out  1  combinational: freeze PC and IF/ID this cycle.
- stall_count  out  CNT_W  number of hazard cycles, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage registers clear: wb_en=0, mem_r_en=0, dst=0.
  - stall_count=0.
  - hazard_detected therefore evaluates to 0.
- Stage registers advance every rising clk:
  - WB <= MEM.
  - MEM <= EXE. MEM keeps wb_en and dst only; the load flag is dropped.
  - EXE <= ID when ID_valid=1, hazard_detected=0 and flush=0.
  - Otherwise EXE <= bubble (wb_en=0, mem_r_en=0, dst=0).
  - No freeze input exists: MEM and WB always advance.
- Source match definitions, for stage S:
  - match1(S) = S_wb_en && S_dst==ID_src1.
  - match2(S) = S_wb_en && S_dst==ID_src2 && ID_two_src.
  - match(S) = match1(S) | match2(S).
- hazard_detected, combinational, gated by ID_valid && !flush:
  - en_forwarding=0: hazard = match(EXE) | match(MEM). WB is never a hazard because the register file writes before it is read in the same cycle.
  - en_forwarding=1: hazard = EXE_mem_r_en && match(EXE) (load-use only). MEM and WB results reach EXE through the forwarding muxes.
- Stall lengths:
  - A load-use stall lasts exactly 1 cycle. After the bubble the load sits in WB when the dependent instruction reaches EXE.
  - A non-forwarding stall lasts up to 2 cycles.
- Register 0 receives no special treatment: a match on dst 0 with wb_en=1 is a hazard.
- ID_dst is ignored when ID_wb_en=0. It is still captured into EXE, but with wb_en=0 it can never match.
- stall_count increments by 1 on each rising edge where hazard_detected=1. It holds at all-ones (saturates) and never wraps.
- Simultaneous flush and hazard: flush wins. hazard_detected=0, a bubble enters EXE, and the counter does not increment.
- Reset asserted mid-stall clears the pipeline immediately. hazard_detected drops in the same cycle, since it depends only on cleared state.
- hazard_detected is a pure function of the current register state and the ID inputs, with no extra latency. All exported stage outputs are register outputs.

Test Plan:
- Reset release, then ID_valid=1, wb_en=1, dst=2, no sources matching → after 1 clk EXE_dst=2/EXE_wb_en=1; after 2 clk MEM_dst=2/MEM_wb_en=1; after 3 clk WB_dst=2/WB_wb_en=1; hazard_detected=0 throughout.
- en_forwarding=0: issue write to r3, then an instruction with src1=3 → hazard_detected=1 for 2 cycles, 2 bubbles enter EXE, stall_count=2; the instruction enters EXE on the 3rd edge.
- en_forwarding=1: issue load (mem_r_en=1, dst=5), then an instruction with src2=5 and two_src=1 → hazard_detected=1 for exactly 1 cycle, stall_count=1. Same sequence with two_src=0 → no hazard.
- en_forwarding=1: non-load write to r4, then src1=4 → hazard_detected=0; the next cycle shows MEM_dst=4 and MEM_wb_en=1 for the forwarding unit.
- Hazard condition present while flush=1 → hazard_detected=0, EXE receives a bubble, stall_count unchanged.
- Force CNT_W=4 and hold a hazard for 20 cycles → stall_count stops at 15. Assert rst mid-stall → all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hazard_tracker.sv
// Tracks destination/write-enable of instructions in EXE, MEM and WB and decides
// when the ID-stage instruction must stall; also counts stall cycles (saturating).
module hazard_tracker #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_forwarding,
    input  logic                  flush,
    input  logic                  ID_valid,
    input  logic                  ID_wb_en,
    input  logic                  ID_mem_r_en,
    input  logic [REG_ADDR_W-1:0] ID_dst,
    input  logic [REG_ADDR_W-1:0] ID_src1,
    input  logic [REG_ADDR_W-1:0] ID_src2,
    input  logic                  ID_two_src,
    output logic                  EXE_wb_en,
    output logic [REG_ADDR_W-1:0] EXE_dst,
    output logic                  EXE_mem_r_en,
    output logic                  MEM_wb_en,
    output logic [REG_ADDR_W-1:0] MEM_dst,
    output logic                  WB_wb_en,
    output logic [REG_ADDR_W-1:0] WB_dst,
    output logic                  hazard_detected,
    output logic [CNT_W-1:0]      stall_count
);

    logic                  exe_wb_en_q, exe_wb_en_d;
    logic                  exe_mem_r_en_q, exe_mem_r_en_d;
    logic [REG_ADDR_W-1:0] exe_dst_q, exe_dst_d;
    logic                  mem_wb_en_q;
    logic [REG_ADDR_W-1:0] mem_dst_q;
    logic                  wb_wb_en_q;
    logic [REG_ADDR_W-1:0] wb_dst_q;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic match_exe, match_mem, id_live, issue;

    // Register 0 is deliberately not special-cased.
    always_comb begin
        match_exe = exe_wb_en_q &&
                    ((exe_dst_q == ID_src1) || ((exe_dst_q == ID_src2) && ID_two_src));
        match_mem = mem_wb_en_q &&
                    ((mem_dst_q == ID_src1) || ((mem_dst_q == ID_src2) && ID_two_src));
    end

    always_comb begin
        id_live = ID_valid && !flush;
        if (en_forwarding)
            hazard_detected = id_live && exe_mem_r_en_q && match_exe;
        else
            hazard_detected = id_live && (match_exe || match_mem);
    end

    always_comb begin
        issue = ID_valid && !hazard_detected && !flush;
        exe_wb_en_d    = 1'b0;
        exe_mem_r_en_d = 1'b0;
        exe_dst_d      = '0;
        if (issue) begin
            exe_wb_en_d    = ID_wb_en;
            exe_mem_r_en_d = ID_mem_r_en;
            exe_dst_d      = ID_dst;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_detected && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_wb_en_q    <= 1'b0;
            exe_mem_r_en_q <= 1'b0;
            exe_dst_q      <= '0;
            mem_wb_en_q    <= 1'b0;
            mem_dst_q      <= '0;
            wb_wb_en_q     <= 1'b0;
            wb_dst_q       <= '0;
            stall_cnt_q    <= '0;
        end else begin
            exe_wb_en_q    <= exe_wb_en_d;
            exe_mem_r_en_q <= exe_mem_r_en_d;
            exe_dst_q      <= exe_dst_d;
            mem_wb_en_q    <= exe_wb_en_q;
            mem_dst_q      <= exe_dst_q;
            wb_wb_en_q     <= mem_wb_en_q;
            wb_dst_q       <= mem_dst_q;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign EXE_wb_en    = exe_wb_en_q;
    assign EXE_dst      = exe_dst_q;
    assign EXE_mem_r_en = exe_mem_r_en_q;
    assign MEM_wb_en    = mem_wb_en_q;
    assign MEM_dst      = mem_dst_q;
    assign WB_wb_en     = wb_wb_en_q;
    assign WB_dst       = wb_dst_q;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker; a second instance with a 4-bit counter
// shares the stimulus and is used for the saturation check.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_forwarding = 1'b0;
    logic       flush = 1'b0;
    logic       ID_valid = 1'b0;
    logic       ID_wb_en = 1'b0;
    logic       ID_mem_r_en = 1'b0;
    logic [3:0] ID_dst = '0;
    logic [3:0] ID_src1 = '0;
    logic [3:0] ID_src2 = '0;
    logic       ID_two_src = 1'b0;

    logic       EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en, hazard_detected;
    logic [3:0] EXE_dst, MEM_dst, WB_dst;
    logic [15:0] stall_count;

    logic       s_EXE_wb_en, s_EXE_mem_r_en, s_MEM_wb_en, s_WB_wb_en, s_hazard;
    logic [3:0] s_EXE_dst, s_MEM_dst, s_WB_dst;
    logic [3:0] s_stall_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .flush(flush),
        .ID_valid(ID_valid), .ID_wb_en(ID_wb_en), .ID_mem_r_en(ID_mem_r_en),
        .ID_dst(ID_dst), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
        .EXE_wb_en(EXE_wb_en), .EXE_dst(EXE_dst), .EXE_mem_r_en(EXE_mem_r_en),
        .MEM_wb_en(MEM_wb_en), .MEM_dst(MEM_dst), .WB_wb_en(WB_wb_en), .WB_dst(WB_dst),
        .hazard_detected(hazard_detected), .stall_count(stall_count)
    );

    hazard_tracker #(.REG_ADDR_W(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .flush(flush),
        .ID_valid(ID_valid), .ID_wb_en(ID_wb_en), .ID_mem_r_en(ID_mem_r_en),
        .ID_dst(ID_dst), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
        .EXE_wb_en(s_EXE_wb_en), .EXE_dst(s_EXE_dst), .EXE_mem_r_en(s_EXE_mem_r_en),
        .MEM_wb_en(s_MEM_wb_en), .MEM_dst(s_MEM_dst), .WB_wb_en(s_WB_wb_en), .WB_dst(s_WB_dst),
        .hazard_detected(s_hazard), .stall_count(s_stall_count)
    );

    // Inputs change 1ns after the rising edge; checks happen 2ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic wb, input logic ld, input logic [3:0] dst,
                         input logic [3:0] s1, input logic [3:0] s2, input logic two);
        ID_valid = 1'b1; ID_wb_en = wb; ID_mem_r_en = ld; ID_dst = dst;
        ID_src1 = s1; ID_src2 = s2; ID_two_src = two;
    endtask

    task automatic idle(input int n);
        ID_valid = 1'b0; ID_wb_en = 1'b0; ID_mem_r_en = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        issue(1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b1);
        settle();
        total++;
        if (hazard_detected !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", hazard_detected); end
        total++;
        if ({EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en} !== 4'b0 ||
            {EXE_dst, MEM_dst, WB_dst} !== 12'h0) begin
            bad++; $display("FAIL reset_stages got=%b/%h exp=0", {EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en}, {EXE_dst, MEM_dst, WB_dst});
        end
        total++;
        if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
        ID_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_pipeline();
        en_forwarding = 1'b0;
        issue(1'b1, 1'b0, 4'd2, 4'd7, 4'd8, 1'b1);
        settle();
        total++;
        if (hazard_detected !== 1'b0) begin bad++; $display("FAIL pipe_haz0 got=%b exp=0", hazard_detected); end
        step();
        ID_valid = 1'b0;
        settle();
        total++;
        if (EXE_dst !== 4'd2 || EXE_wb_en !== 1'b1) begin bad++; $display("FAIL pipe_exe got=%0d/%b exp=2/1", EXE_dst, EXE_wb_en); end
        step(); settle();
        total++;
        if (MEM_dst !== 4'd2 || MEM_wb_en !== 1'b1 || EXE_wb_en !== 1'b0) begin
            bad++; $display("FAIL pipe_mem got=%0d/%b exe_wb=%b exp=2/1/0", MEM_dst, MEM_wb_en, EXE_wb_en);
        end
        step(); settle();
        total++;
        if (WB_dst !== 4'd2 || WB_wb_en !== 1'b1 || hazard_detected !== 1'b0) begin
            bad++; $display("FAIL pipe_wb got=%0d/%b haz=%b exp=2/1/0", WB_dst, WB_wb_en, hazard_detected);
        end
        idle(3);
    endtask

    task automatic test_nofwd_stall();
        logic [15:0] base;
        en_forwarding = 1'b0;
        base = stall_count;
        issue(1'b1, 1'b0, 4'd3, 4'd9, 4'd10, 1'b0);
        step();
        issue(1'b1, 1'b0, 4'd6, 4'd3, 4'd11, 1'b0);
        settle();
        total++;
        if (hazard_detected !== 1'b1) begin bad++; $display("FAIL nofwd_haz_c1 got=%b exp=1", hazard_detected); end
        step(); settle();
        total++;
        if (hazard_detected !== 1'b1 || EXE_wb_en !== 1'b0 || MEM_dst !== 4'd3) begin
            bad++; $display("FAIL nofwd_haz_c2 got=%b exe_wb=%b mem_dst=%0d exp=1/0/3", hazard_detected, EXE_wb_en, MEM_dst);
        end
        step(); settle();
        total++;
        if (hazard_detected !== 1'b0 || EXE_wb_en !== 1'b0 || stall_count !== base + 16'd2) begin
            bad++; $display("FAIL nofwd_release got=%b exe_wb=%b cnt=%0d exp=0/0/%0d", hazard_detected, EXE_wb_en, stall_count, base + 16'd2);
        end
        step();
        ID_valid = 1'b0;
        settle();
        total++;
        if (EXE_dst !== 4'd6 || EXE_wb_en !== 1'b1) begin bad++; $display("FAIL nofwd_enter got=%0d/%b exp=6/1", EXE_dst, EXE_wb_en); end
        idle(3);
    endtask

    task automatic test_load_use();
        logic [15:0] base;
        en_forwarding = 1'b1;
        base = stall_count;
        issue(1'b1, 1'b1, 4'd5, 4'd1, 4'd2, 1'b1);
        step();
        issue(1'b1, 1'b0, 4'd7, 4'd9, 4'd5, 1'b1);
        settle();
        total++;
        if (hazard_detected !== 1'b1 || EXE_mem_r_en !== 1'b1) begin
            bad++; $display("FAIL lu_haz got=%b ld=%b exp=1/1", hazard_detected, EXE_mem_r_en);
        end
        step(); settle();
        total++;
        if (hazard_detected !== 1'b0 || EXE_wb_en !== 1'b0 || stall_count !== base + 16'd1) begin
            bad++; $display("FAIL lu_one_cycle got=%b exe_wb=%b cnt=%0d exp=0/0/%0d", hazard_detected, EXE_wb_en, stall_count, base + 16'd1);
        end
        step();
        ID_valid = 1'b0;
        settle();
        total++;
        if (EXE_dst !== 4'd7 || EXE_wb_en !== 1'b1 || EXE_mem_r_en !== 1'b0) begin
            bad++; $display("FAIL lu_enter got=%0d/%b/%b exp=7/1/0", EXE_dst, EXE_wb_en, EXE_mem_r_en);
        end
        idle(3);
        base = stall_count;
        issue(1'b1, 1'b1, 4'd5, 4'd1, 4'd2, 1'b1);
        step();
        issue(1'b1, 1'b0, 4'd7, 4'd9, 4'd5, 1'b0);
        settle();
        total++;
        if (hazard_detected !== 1'b0) begin bad++; $display("FAIL lu_one_src got=%b exp=0", hazard_detected); end
        step();
        ID_valid = 1'b0;
        settle();
        total++;
        if (EXE_dst !== 4'd7 || EXE_wb_en !== 1'b1 || stall_count !== base) begin
            bad++; $display("FAIL lu_one_src_enter got=%0d/%b cnt=%0d exp=7/1/%0d", EXE_dst, EXE_wb_en, stall_count, base);
        end
        idle(3);
    endtask

    task automatic test_forward_nonload();
        en_forwarding = 1'b1;
        issue(1'b1, 1'b0, 4'd4, 4'd1, 4'd2, 1'b0);
        step();
        issue(1'b1, 1'b0, 4'd8, 4'd4, 4'd4, 1'b1);
        settle();
        total++;
        if (hazard_detected !== 1'b0) begin bad++; $display("FAIL fwd_nohaz got=%b exp=0", hazard_detected); end
        step();
        ID_valid = 1'b0;
        settle();
        total++;
        if (MEM_dst !== 4'd4 || MEM_wb_en !== 1'b1 || EXE_dst !== 4'd8) begin
            bad++; $display("FAIL fwd_mem got=%0d/%b exe=%0d exp=4/1/8", MEM_dst, MEM_wb_en, EXE_dst);
        end
        idle(3);
    endtask

    task automatic test_flush();
        logic [15:0] base;
        en_forwarding = 1'b0;
        base = stall_count;
        issue(1'b1, 1'b0, 4'd3, 4'd1, 4'd2, 1'b0);
        step();
        issue(1'b1, 1'b0, 4'd9, 4'd3, 4'd2, 1'b0);
        flush = 1'b1;
        settle();
        total++;
        if (hazard_detected !== 1'b0) begin bad++; $display("FAIL flush_haz got=%b exp=0", hazard_detected); end
        step();
        flush = 1'b0;
        settle();
        total++;
        if (EXE_wb_en !== 1'b0 || EXE_dst !== 4'd0 || stall_count !== base) begin
            bad++; $display("FAIL flush_bubble got=%b/%0d cnt=%0d exp=0/0/%0d", EXE_wb_en, EXE_dst, stall_count, base);
        end
        total++;
        if (hazard_detected !== 1'b1) begin bad++; $display("FAIL flush_release_mem got=%b exp=1", hazard_detected); end
        idle(3);
    endtask

    task automatic test_reg0_and_nowb();
        en_forwarding = 1'b0;
        issue(1'b1, 1'b0, 4'd0, 4'd5, 4'd6, 1'b0);
        step();
        issue(1'b1, 1'b0, 4'd2, 4'd0, 4'd6, 1'b0);
        settle();
        total++;
        if (hazard_detected !== 1'b1) begin bad++; $display("FAIL reg0_haz got=%b exp=1", hazard_detected); end
        idle(4);
        issue(1'b0, 1'b0, 4'd3, 4'd5, 4'd6, 1'b0);
        step();
        issue(1'b1, 1'b0, 4'd2, 4'd3, 4'd3, 1'b1);
        settle();
        total++;
        if (hazard_detected !== 1'b0 || EXE_dst !== 4'd3 || EXE_wb_en !== 1'b0) begin
            bad++; $display("FAIL nowb got=%b dst=%0d wb=%b exp=0/3/0", hazard_detected, EXE_dst, EXE_wb_en);
        end
        idle(3);
    endtask

    task automatic test_saturate_and_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        en_forwarding = 1'b0;
        // Self-dependent instruction held in ID: 2 hazard cycles out of every 3.
        issue(1'b1, 1'b0, 4'd1, 4'd1, 4'd2, 1'b0);
        for (int i = 0; i < 33; i++) step();
        settle();
        total++;
        if (stall_count !== 16'd22) begin bad++; $display("FAIL sat_wide_count got=%0d exp=22", stall_count); end
        total++;
        if (s_stall_count !== 4'd15) begin bad++; $display("FAIL sat_small_count got=%0d exp=15", s_stall_count); end
        step();
        total++;
        if (hazard_detected !== 1'b1) begin bad++; $display("FAIL sat_midstall got=%b exp=1", hazard_detected); end
        #1 rst = 1'b0;
        #1;
        total++;
        if (hazard_detected !== 1'b0 || s_hazard !== 1'b0) begin
            bad++; $display("FAIL rst_async_haz got=%b/%b exp=0/0", hazard_detected, s_hazard);
        end
        total++;
        if ({EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en} !== 4'b0 ||
            {EXE_dst, MEM_dst, WB_dst} !== 12'h0 || stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
            bad++; $display("FAIL rst_async_state got=%b/%h cnt=%0d/%0d exp=0", {EXE_wb_en, EXE_mem_r_en, MEM_wb_en, WB_wb_en}, {EXE_dst, MEM_dst, WB_dst}, stall_count, s_stall_count);
        end
        ID_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_nofwd_stall();
        test_load_use();
        test_forward_nonload();
        test_flush();
        test_reg0_and_nowb();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
